// File: rtl/ryuki_datatypes.sv
// Shared trace record types for the per-stage pipeline trackers.
// Holds the trace_output record and the ID-stage timestamp helpers.
package ryuki_datatypes;

    localparam int TRACE_ADDR_W = 32;
    localparam int TRACE_DATA_W = 32;
    localparam int TRACE_TIME_W = 32;

    typedef struct packed {
        logic [TRACE_TIME_W-1:0] time_start;
        logic [TRACE_TIME_W-1:0] time_end;
    } if_data_t;

    typedef struct packed {
        logic [TRACE_TIME_W-1:0] time_start;
        logic [TRACE_TIME_W-1:0] time_end;
    } id_data_t;

    typedef struct packed {
        logic [TRACE_ADDR_W-1:0] addr;
        logic [TRACE_DATA_W-1:0] instruction;
        if_data_t                if_data;
        id_data_t                id_data;
    } trace_output;

    // The end stamp is cleared on start so a stale value can never leak out.
    function automatic trace_output id_stamp_start(input trace_output rec,
                                                   input logic [TRACE_TIME_W-1:0] t);
        trace_output r;
        r                    = rec;
        r.id_data.time_start = t;
        r.id_data.time_end   = {TRACE_TIME_W{1'b0}};
        return r;
    endfunction

    function automatic trace_output id_stamp_end(input trace_output rec,
                                                 input logic [TRACE_TIME_W-1:0] t);
        trace_output r;
        r                  = rec;
        r.id_data.time_end = t;
        return r;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO of trace records shared by the stage trackers.
// A pop frees the head slot, so a push into a full FIFO succeeds when it pairs with a pop.
module trace_fifo
    import ryuki_datatypes::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  trace_output            din,
    output trace_output            dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    trace_output      mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;
    logic             full_s;
    logic             empty_s;

    assign full_s  = (count_r == CNT_W'(DEPTH));
    assign empty_s = (count_r == {CNT_W{1'b0}});
    assign full    = full_s;
    assign empty   = empty_s;
    assign count   = count_r;
    assign dout    = mem_r[rd_ptr_r];

    // Qualify requests: clear wins, and a full FIFO only accepts alongside a pop.
    always_comb begin
        do_pop_s  = pop && !empty_s && !clear;
        do_push_s = push && !clear && (!full_s || do_pop_s);
    end

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (clear) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/id_tracker.sv
// Decode-stage trace tracker: matches buffered fetch records against the ID
// instruction, stamps decode start/end times and emits one record per decode.
module id_tracker
    import ryuki_datatypes::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        if_data_ready,
    input  trace_output                 if_data_i,
    input  logic                        id_valid,
    input  logic [DATA_WIDTH-1:0]       id_instr,
    input  logic                        id_done,
    input  logic                        id_flush,
    input  logic [31:0]                 counter,
    output logic                        id_data_ready,
    output trace_output                 id_data_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow,
    output logic                        mismatch
);

    if (ADDR_WIDTH != TRACE_ADDR_W || DATA_WIDTH != TRACE_DATA_W) begin : g_width_check
        $error("id_tracker: ADDR_WIDTH/DATA_WIDTH must match the trace_output record");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
        $error("id_tracker: FIFO_DEPTH must be a power of two, at least 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EMIT
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic        if_ready_q_r;
    logic        push_req_s;
    logic        pop_s;
    logic        match_s;
    logic        emit_s;
    logic        fifo_full_s;
    logic        fifo_empty_s;
    trace_output head_s;
    trace_output start_rec_s;
    trace_output end_rec_s;
    trace_output work_r;
    logic        id_data_ready_r;
    trace_output id_data_o_r;
    logic        overflow_r;
    logic        mismatch_r;

    assign start_rec_s = id_stamp_start(head_s, counter);
    assign end_rec_s   = id_stamp_end(work_r, counter);

    trace_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (id_flush),
        .push  (push_req_s),
        .pop   (pop_s),
        .din   (if_data_i),
        .dout  (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count)
    );

    // Next-state, pop and emit decode; a flush overrides everything else.
    always_comb begin
        state_s    = state_r;
        pop_s      = 1'b0;
        emit_s     = 1'b0;
        match_s    = (head_s.instruction == id_instr);
        push_req_s = if_data_ready && !if_ready_q_r && !id_flush;
        if (id_flush) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (id_valid && !fifo_empty_s) begin
                        pop_s = 1'b1;
                        if (match_s) begin
                            state_s = ST_DECODE;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_DECODE: begin
                    if (id_done) begin
                        emit_s  = 1'b1;
                        state_s = ST_EMIT;
                    end else begin
                        state_s = ST_DECODE;
                    end
                end
                ST_EMIT: state_s = ST_IDLE;
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // State, edge detect, working record and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            if_ready_q_r    <= 1'b0;
            work_r          <= '0;
            id_data_ready_r <= 1'b0;
            id_data_o_r     <= '0;
            overflow_r      <= 1'b0;
            mismatch_r      <= 1'b0;
        end else begin
            state_r         <= state_s;
            if_ready_q_r    <= if_data_ready;
            id_data_ready_r <= emit_s;
            if (id_flush) begin
                work_r <= '0;
            end else if (pop_s && match_s) begin
                work_r <= start_rec_s;
            end else if (emit_s) begin
                work_r <= end_rec_s;
            end
            if (emit_s) begin
                id_data_o_r <= end_rec_s;
            end
            if (push_req_s && fifo_full_s && !pop_s) begin
                overflow_r <= 1'b1;
            end
            if (pop_s && !match_s) begin
                mismatch_r <= 1'b1;
            end
        end
    end

    assign id_data_ready = id_data_ready_r;
    assign id_data_o     = id_data_o_r;
    assign overflow      = overflow_r;
    assign mismatch      = mismatch_r;

endmodule

// File: tb/tb_id_tracker.sv
// Self-checking bench for id_tracker: table-driven single decodes plus directed
// corner sequences, with emitted records checked against a scoreboard queue.
module tb_id_tracker;
    import ryuki_datatypes::*;

    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   if_data_ready;
    trace_output            if_data_i;
    logic                   id_valid;
    logic [31:0]            id_instr;
    logic                   id_done;
    logic                   id_flush;
    logic [31:0]            counter;
    logic                   id_data_ready;
    trace_output            id_data_o;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   overflow;
    logic                   mismatch;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] cnt      = 32'd0;
    trace_output exp_q[$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] if_s;
        logic [31:0] if_e;
        int          pre_gap;
        int          ndec;
    } vec_t;

    always #5 clk = ~clk;

    id_tracker #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_data_ready (if_data_ready),
        .if_data_i     (if_data_i),
        .id_valid      (id_valid),
        .id_instr      (id_instr),
        .id_done       (id_done),
        .id_flush      (id_flush),
        .counter       (counter),
        .id_data_ready (id_data_ready),
        .id_data_o     (id_data_o),
        .fifo_count    (fifo_count),
        .overflow      (overflow),
        .mismatch      (mismatch)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %08h required %08h", name, act, req);
        end
    endtask

    // Compare every emitted record against the oldest expectation.
    task automatic monitor();
        trace_output e;
        if (id_data_ready !== 1'b0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_emit", {31'd0, id_data_ready}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("emit_addr",     id_data_o.addr,               e.addr);
                check("emit_instr",    id_data_o.instruction,        e.instruction);
                check("emit_if_start", id_data_o.if_data.time_start, e.if_data.time_start);
                check("emit_if_end",   id_data_o.if_data.time_end,   e.if_data.time_end);
                check("emit_id_start", id_data_o.id_data.time_start, e.id_data.time_start);
                check("emit_id_end",   id_data_o.id_data.time_end,   e.id_data.time_end);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cnt     = cnt + 32'd1;
        counter = cnt;
        monitor();
    endtask

    function automatic trace_output mk_rec(input logic [31:0] a, input logic [31:0] i,
                                           input logic [31:0] s, input logic [31:0] e);
        trace_output r;
        r                    = '0;
        r.addr               = a;
        r.instruction        = i;
        r.if_data.time_start = s;
        r.if_data.time_end   = e;
        return r;
    endfunction

    task automatic do_reset();
        rst           = 1'b1;
        if_data_ready = 1'b0;
        id_valid      = 1'b0;
        id_done       = 1'b0;
        id_flush      = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push_rec(input trace_output rec);
        if_data_i     = rec;
        if_data_ready = 1'b1;
        tick();
        if_data_ready = 1'b0;
        tick();
    endtask

    // Record already popped at c_pop: wait in DECODE, raise id_done, expect the pulse next cycle.
    task automatic finish_decode(input trace_output rec, input logic [31:0] c_pop, input int nwait);
        trace_output e;
        repeat (nwait) tick();
        id_done = 1'b1;
        e = rec;
        e.id_data.time_start = c_pop;
        e.id_data.time_end   = cnt;
        exp_q.push_back(e);
        tick();
        check("emit_latency", {31'd0, id_data_ready}, 32'd1);
        id_done = 1'b0;
        tick();
    endtask

    task automatic decode_one(input trace_output rec, input int nwait);
        logic [31:0] c_pop;
        id_valid = 1'b1;
        id_instr = rec.instruction;
        c_pop    = cnt;
        tick();
        id_valid = 1'b0;
        finish_decode(rec, c_pop, nwait);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[4];
        trace_output f[5];
        trace_output a_rec;
        trace_output b_rec;
        logic [31:0] c_pop;

        vecs[0] = '{32'h0000_1000, 32'h0010_0093, 32'd3,  32'd4,  0, 0};
        vecs[1] = '{32'h0000_1004, 32'h0020_8113, 32'd7,  32'd9,  2, 1};
        vecs[2] = '{32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'd11, 32'd11, 1, 3};
        vecs[3] = '{32'h8000_0000, 32'h0000_0000, 32'd20, 32'd25, 3, 2};

        rst           = 1'b1;
        if_data_ready = 1'b0;
        if_data_i     = '0;
        id_valid      = 1'b0;
        id_instr      = 32'd0;
        id_done       = 1'b0;
        id_flush      = 1'b0;
        counter       = cnt;
        do_reset();

        check("rst_ready",    {31'd0, id_data_ready}, 32'd0);
        check("rst_data",     id_data_o.instruction, 32'd0);
        check("rst_count",    32'(fifo_count), 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_mismatch", {31'd0, mismatch}, 32'd0);

        // Push at 10, match at 12, id_done at 15, pulse visible at 16.
        while (cnt < 32'd10) tick();
        f[0] = mk_rec(32'h0000_0100, 32'h0000_0013, 32'd8, 32'd9);
        push_rec(f[0]);
        decode_one(f[0], 2);

        for (int i = 0; i < 4; i++) begin
            f[0] = mk_rec(vecs[i].addr, vecs[i].instr, vecs[i].if_s, vecs[i].if_e);
            push_rec(f[0]);
            repeat (vecs[i].pre_gap) tick();
            check("table_count", 32'(fifo_count), 32'd1);
            decode_one(f[0], vecs[i].ndec);
        end

        // Push and pop together while full.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            f[i] = mk_rec(32'h0000_2000 + 32'(i * 4), 32'h1111_0000 + 32'(i), 32'(i), 32'(i + 1));
            push_rec(f[i]);
        end
        f[4] = mk_rec(32'h0000_2010, 32'h1111_0004, 32'd40, 32'd41);
        check("full_count", 32'(fifo_count), 32'd4);
        if_data_i     = f[4];
        if_data_ready = 1'b1;
        id_valid      = 1'b1;
        id_instr      = f[0].instruction;
        c_pop         = cnt;
        tick();
        if_data_ready = 1'b0;
        id_valid      = 1'b0;
        check("pushpop_count",    32'(fifo_count), 32'd4);
        check("pushpop_overflow", {31'd0, overflow}, 32'd0);
        finish_decode(f[0], c_pop, 0);
        for (int i = 1; i < 5; i++) decode_one(f[i], 1);
        check("pushpop_drained", 32'(fifo_count), 32'd0);

        // Five pushes into four slots: the fifth is dropped.
        for (int i = 0; i < 5; i++) begin
            f[i] = mk_rec(32'h0000_3000 + 32'(i * 4), 32'h2222_0000 + 32'(i), 32'd50, 32'd51);
            push_rec(f[i]);
        end
        check("ovf_count", 32'(fifo_count), 32'd4);
        check("ovf_flag",  {31'd0, overflow}, 32'd1);
        for (int i = 0; i < 4; i++) decode_one(f[i], 0);
        id_valid = 1'b1;
        id_instr = f[4].instruction;
        tick();
        tick();
        id_valid = 1'b0;
        check("ovf_dropped", 32'(fifo_count), 32'd0);

        // Head mismatch is discarded, following record matches.
        a_rec = mk_rec(32'h0000_4000, 32'hAAAA_0000, 32'd60, 32'd61);
        b_rec = mk_rec(32'h0000_4004, 32'hBBBB_0000, 32'd62, 32'd63);
        push_rec(a_rec);
        push_rec(b_rec);
        id_valid = 1'b1;
        id_instr = b_rec.instruction;
        tick();
        check("mm_flag",  {31'd0, mismatch}, 32'd1);
        check("mm_count", 32'(fifo_count), 32'd1);
        c_pop = cnt;
        tick();
        id_valid = 1'b0;
        check("mm_popped", 32'(fifo_count), 32'd0);
        finish_decode(b_rec, c_pop, 1);

        // Flush in DECODE with two queued, coinciding with id_done.
        for (int i = 0; i < 3; i++) begin
            f[i] = mk_rec(32'h0000_5000 + 32'(i * 4), 32'h3333_0000 + 32'(i), 32'd70, 32'd71);
            push_rec(f[i]);
        end
        id_valid = 1'b1;
        id_instr = f[0].instruction;
        tick();
        id_valid = 1'b0;
        check("fl_queued", 32'(fifo_count), 32'd2);
        tick();
        id_flush = 1'b1;
        id_done  = 1'b1;
        tick();
        id_flush = 1'b0;
        id_done  = 1'b0;
        check("fl_count",    32'(fifo_count), 32'd0);
        check("fl_no_pulse", {31'd0, id_data_ready}, 32'd0);
        check("fl_mismatch", {31'd0, mismatch}, 32'd1);
        check("fl_overflow", {31'd0, overflow}, 32'd1);
        tick();
        tick();
        f[3] = mk_rec(32'h0000_500C, 32'h3333_0003, 32'd80, 32'd81);
        push_rec(f[3]);
        decode_one(f[3], 0);

        // Asynchronous reset while in DECODE.
        f[0] = mk_rec(32'h0000_6000, 32'h4444_0000, 32'd90, 32'd91);
        f[1] = mk_rec(32'h0000_6004, 32'h4444_0001, 32'd92, 32'd93);
        push_rec(f[0]);
        push_rec(f[1]);
        id_valid = 1'b1;
        id_instr = f[0].instruction;
        tick();
        id_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("arst_ready",    {31'd0, id_data_ready}, 32'd0);
        check("arst_addr",     id_data_o.addr, 32'd0);
        check("arst_id_end",   id_data_o.id_data.time_end, 32'd0);
        check("arst_count",    32'(fifo_count), 32'd0);
        check("arst_overflow", {31'd0, overflow}, 32'd0);
        check("arst_mismatch", {31'd0, mismatch}, 32'd0);
        tick();
        rst = 1'b0;
        f[2] = mk_rec(32'h0000_7000, 32'h5555_0000, 32'd100, 32'd101);
        push_rec(f[2]);
        check("post_rst_count", 32'(fifo_count), 32'd1);
        decode_one(f[2], 1);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
